// File: rtl/aes_result_scanner_if.sv
// Bundle between the AES result scanner and its driver: control, result/golden
// vectors in, display byte bus and status out.
interface aes_result_scanner_if;
  logic         start;
  logic         pause;
  logic [127:0] result;
  logic [127:0] expected;
  logic [7:0]   byte_out;
  logic [3:0]   byte_idx;
  logic         valid;
  logic         isEqual;
  logic         busy;
  logic         done;

  modport master (
    output start, pause, result, expected,
    input  byte_out, byte_idx, valid, isEqual, busy, done
  );

  modport slave (
    input  start, pause, result, expected,
    output byte_out, byte_idx, valid, isEqual, busy, done
  );
endinterface

// File: rtl/aes_result_scanner.sv
// Waits a settle period after start, snapshots the AES result, flags a match against the
// golden vector, then walks the 16 snapshot bytes one per dwell period on a byte bus.
module aes_result_scanner #(
  parameter int unsigned TICK_DIV      = 50_000_000,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter bit          LOOP          = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  aes_result_scanner_if.slave bus
);

  localparam int unsigned DwellW  = $clog2(TICK_DIV);
  localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [DwellW-1:0]  DwellLast  = DwellW'(TICK_DIV - 1);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StSnap,
    StScan,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [SettleW-1:0]   settle_q, settle_d;
  logic [DwellW-1:0]    dwell_q, dwell_d;
  logic [127:0]         shadow_q, shadow_d;
  logic [7:0]           byte_q, byte_d;
  logic [3:0]           idx_q, idx_d;
  logic                 valid_q, valid_d;
  logic                 eq_q, eq_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [3:0]           idx_inc;
  logic [6:0]           sel_lsb;

  // Byte n of the snapshot lives at bits [127-8n -: 8]; ~n*8 is its LSB position.
  assign idx_inc = idx_q + 4'd1;
  assign sel_lsb = {~idx_inc, 3'b000};

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    dwell_d  = dwell_q;
    shadow_d = shadow_q;
    byte_d   = byte_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    eq_d     = eq_q;

    if (bus.start) begin
      // Restart from any state; outranks pause and dwell expiry.
      state_d  = StSettle;
      settle_d = '0;
      dwell_d  = '0;
      valid_d  = 1'b0;
      eq_d     = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StSettle: begin
          if (settle_q == SettleLast) begin
            settle_d = '0;
            state_d  = StSnap;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
        StSnap: begin
          shadow_d = bus.result;
          eq_d     = (bus.result == bus.expected);
          byte_d   = bus.result[127:120];
          idx_d    = 4'd0;
          valid_d  = 1'b1;
          dwell_d  = '0;
          state_d  = StScan;
        end
        StScan: begin
          if (!bus.pause) begin
            if (dwell_q == DwellLast) begin
              dwell_d = '0;
              if (idx_q == 4'd15 && !LOOP) begin
                state_d = StDone;
              end else begin
                // idx_inc wraps 15 -> 0, which also covers the looping case.
                idx_d  = idx_inc;
                byte_d = shadow_q[sel_lsb +: 8];
              end
            end else begin
              dwell_d = dwell_q + 1'b1;
            end
          end
        end
        StDone: begin
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    busy_d = (state_d == StSettle) || (state_d == StSnap) || (state_d == StScan);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      settle_q <= '0;
      dwell_q  <= '0;
      shadow_q <= '0;
      byte_q   <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      eq_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      dwell_q  <= dwell_d;
      shadow_q <= shadow_d;
      byte_q   <= byte_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      eq_q     <= eq_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.byte_out = byte_q;
  assign bus.byte_idx = idx_q;
  assign bus.valid    = valid_q;
  assign bus.isEqual  = eq_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_aes_result_scanner.sv
// Scoreboard bench for aes_result_scanner: stimulus queues each expected display byte with
// the clock edge it should appear on; a monitor pops and compares on every new byte.
module tb_aes_result_scanner;

  typedef struct {
    int         at_cyc;
    logic [3:0] idx;
    logic [7:0] b;
    logic       eq;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q[$];

  logic [127:0] vec_v = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic [127:0] vec_w = 128'h00112233445566778899aabbccddeeff;
  logic [7:0]   vb[16] = '{8'h69, 8'hc4, 8'he0, 8'hd8, 8'h6a, 8'h7b, 8'h04, 8'h30,
                           8'hd8, 8'hcd, 8'hb7, 8'h80, 8'h70, 8'hb4, 8'hc5, 8'h5a};

  aes_result_scanner_if bus ();
  aes_result_scanner_if bus0 ();

  assign bus0.start    = bus.start;
  assign bus0.pause    = bus.pause;
  assign bus0.result   = bus.result;
  assign bus0.expected = bus.expected;

  aes_result_scanner #(.TICK_DIV(4), .SETTLE_CYCLES(3), .LOOP(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  aes_result_scanner #(.TICK_DIV(4), .SETTLE_CYCLES(3), .LOOP(1'b0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int at_cyc, input int idx, input logic [7:0] b, input logic eq);
    exp_t e;
    e.at_cyc = at_cyc;
    e.idx    = 4'(idx);
    e.b      = b;
    e.eq     = eq;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  // Caller sits at a negedge; start is sampled on the following posedge, returned as s.
  task automatic issue_start(output int s);
    bus.start = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_byte_out"}, bus.byte_out, 0);
    chk({tag, "_byte_idx"}, bus.byte_idx, 0);
    chk({tag, "_valid"},    bus.valid, 0);
    chk({tag, "_isEqual"},  bus.isEqual, 0);
    chk({tag, "_busy"},     bus.busy, 0);
    chk({tag, "_done"},     bus.done, 0);
    chk({tag, "_l0_valid"}, bus0.valid, 0);
    chk({tag, "_l0_done"},  bus0.done, 0);
    chk({tag, "_l0_byte"},  bus0.byte_out, 0);
  endtask

  // Monitor: a new display byte is a valid rise or an index change while valid.
  initial begin
    logic       pv;
    logic [3:0] pidx;
    exp_t       e;
    pv   = 1'b0;
    pidx = 4'd0;
    forever begin
      @(negedge clk);
      if (bus.valid === 1'b1 && (!pv || bus.byte_idx !== pidx)) begin
        if (q.size() == 0) begin
          chk("unexpected_byte_idx", bus.byte_idx, 4'hx);
        end else begin
          e = q.pop_front();
          chk("sb_cycle",    cyc, e.at_cyc);
          chk("sb_byte_idx", bus.byte_idx, e.idx);
          chk("sb_byte_out", bus.byte_out, e.b);
          chk("sb_isEqual",  bus.isEqual, e.eq);
        end
      end
      pv   = bus.valid;
      pidx = bus.byte_idx;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    int s2;
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    bus.result   = '0;
    bus.expected = '0;

    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    chk("idle_valid", bus.valid, 0);

    // Matching vector, full 16-byte walk plus wrap; LOOP=0 copy stops on byte 15.
    bus.result   = vec_v;
    bus.expected = vec_v;
    issue_start(s);
    for (int j = 0; j < 16; j++) push(s + 4 + 4 * j, j, vb[j], 1'b1);
    push(s + 68, 0, 8'h69, 1'b1);
    wait_cyc(s + 1);
    chk("settle_busy", bus.busy, 1);
    chk("settle_valid", bus.valid, 0);
    wait_cyc(s + 67);
    chk("l0_last_idx", bus0.byte_idx, 15);
    chk("l0_last_byte", bus0.byte_out, 8'h5a);
    chk("l0_last_done", bus0.done, 0);
    chk("l0_last_busy", bus0.busy, 1);
    wait_cyc(s + 68);
    chk("l0_done", bus0.done, 1);
    chk("l0_done_busy", bus0.busy, 0);
    chk("l0_done_byte", bus0.byte_out, 8'h5a);
    chk("l0_done_idx", bus0.byte_idx, 15);
    chk("l0_done_valid", bus0.valid, 1);
    chk("l1_wrap_busy", bus.busy, 1);
    chk("l1_wrap_done", bus.done, 0);

    // Mismatching golden vector; pause 10 cycles while byte 3 is shown.
    bus.expected = vec_w;
    issue_start(s);
    for (int j = 0; j < 4; j++) push(s + 4 + 4 * j, j, vb[j], 1'b0);
    push(s + 30, 4, vb[4], 1'b0);
    wait_cyc(s + 17);
    bus.pause = 1'b1;
    wait_cyc(s + 27);
    bus.pause = 1'b0;
    wait_cyc(s + 30);

    // Result changes after snapshot are invisible; restart mid-scan takes a fresh snapshot.
    bus.expected = vec_v;
    issue_start(s);
    push(s + 4, 0, vb[0], 1'b1);
    push(s + 8, 1, vb[1], 1'b1);
    push(s + 12, 2, vb[2], 1'b1);
    wait_cyc(s + 4);
    bus.result = '0;
    wait_cyc(s + 13);
    issue_start(s2);
    chk("restart_valid", bus.valid, 0);
    chk("restart_isEqual", bus.isEqual, 0);
    chk("restart_busy", bus.busy, 1);
    push(s2 + 4, 0, 8'h00, 1'b0);
    wait_cyc(s2 + 5);

    // Asynchronous reset between edges clears everything at once.
    @(posedge clk);
    #3 reset = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk_zero("post_reset_idle");

    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
